// File: rtl/instr_encode.sv
// ============================================================================
// instr_encode : LEGv8 instruction encoder (R/D/CB/B) with valid/ready handoff
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_encode (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  op_sel,
  input  logic [4:0]                  reg_d,
  input  logic [4:0]                  reg_n,
  input  logic [4:0]                  reg_m,
  input  logic signed [`WORD-1:0]     imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`INSTR_LEN-1:0]       instruction_out,
  output logic                        err,
  output logic [15:0]                 instr_count
);

  localparam logic [3:0]  c_SEL_LDUR = 4'd0;
  localparam logic [3:0]  c_SEL_STUR = 4'd1;
  localparam logic [3:0]  c_SEL_ADD  = 4'd2;
  localparam logic [3:0]  c_SEL_SUB  = 4'd3;
  localparam logic [3:0]  c_SEL_AND  = 4'd4;
  localparam logic [3:0]  c_SEL_ORR  = 4'd5;
  localparam logic [3:0]  c_SEL_CBZ  = 4'd6;
  localparam logic [3:0]  c_SEL_B    = 4'd7;

  localparam logic [10:0] c_OPC_LDUR = 11'h7C2;
  localparam logic [10:0] c_OPC_STUR = 11'h7C0;
  localparam logic [10:0] c_OPC_ADD  = 11'h458;
  localparam logic [10:0] c_OPC_SUB  = 11'h658;
  localparam logic [10:0] c_OPC_AND  = 11'h450;
  localparam logic [10:0] c_OPC_ORR  = 11'h550;
  localparam logic [7:0]  c_OPC_CBZ  = 8'hB4;
  localparam logic [5:0]  c_OPC_B    = 6'b000101;

  localparam logic signed [`WORD-1:0] c_D_MIN  = -`WORD'sd256;
  localparam logic signed [`WORD-1:0] c_D_MAX  =  `WORD'sd255;
  localparam logic signed [`WORD-1:0] c_CB_MIN = -`WORD'sd262144;
  localparam logic signed [`WORD-1:0] c_CB_MAX =  `WORD'sd262143;
  localparam logic signed [`WORD-1:0] c_B_MIN  = -`WORD'sd33554432;
  localparam logic signed [`WORD-1:0] c_B_MAX  =  `WORD'sd33554431;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_handoff;

  logic [3:0]                r_op;
  logic [4:0]                r_rd;
  logic [4:0]                r_rn;
  logic [4:0]                r_rm;
  logic signed [`WORD-1:0]   r_imm;

  logic [`INSTR_LEN-1:0]     w_instr;
  logic                      w_err;

  logic                      r_out_valid;
  logic [`INSTR_LEN-1:0]     r_instr;
  logic                      r_err;
  logic [15:0]               r_count;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && !reset) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ENCODE;
        end
      end
      S_ENCODE: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready && !reset) begin
          w_handoff   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Reset is synchronous, so the state alone would still read IDLE while it is held.
  assign in_ready = (r_state == S_IDLE) && !reset;

  // ---------------------------------------------------------------- request capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_rn  <= '0;
      r_rm  <= '0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= op_sel;
      r_rd  <= reg_d;
      r_rn  <= reg_n;
      r_rm  <= reg_m;
      r_imm <= imm;
    end
  end

  // ---------------------------------------------------------------- encoder
  always_comb begin
    w_instr = '0;
    w_err   = 1'b0;
    case (r_op)
      c_SEL_LDUR, c_SEL_STUR: begin
        w_err   = (r_imm < c_D_MIN) || (r_imm > c_D_MAX);
        w_instr = {(r_op == c_SEL_LDUR) ? c_OPC_LDUR : c_OPC_STUR,
                   r_imm[8:0], 2'b00, r_rn, r_rd};
      end
      c_SEL_ADD: w_instr = {c_OPC_ADD, r_rm, 6'd0, r_rn, r_rd};
      c_SEL_SUB: w_instr = {c_OPC_SUB, r_rm, 6'd0, r_rn, r_rd};
      c_SEL_AND: w_instr = {c_OPC_AND, r_rm, 6'd0, r_rn, r_rd};
      c_SEL_ORR: w_instr = {c_OPC_ORR, r_rm, 6'd0, r_rn, r_rd};
      c_SEL_CBZ: begin
        w_err   = (r_imm < c_CB_MIN) || (r_imm > c_CB_MAX);
        w_instr = {c_OPC_CBZ, r_imm[18:0], r_rd};
      end
      c_SEL_B: begin
        w_err   = (r_imm < c_B_MIN) || (r_imm > c_B_MAX);
        w_instr = {c_OPC_B, r_imm[25:0]};
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- result and count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else if (r_state == S_ENCODE) begin
      r_out_valid <= 1'b1;
      r_instr     <= w_err ? '0 : w_instr;
      r_err       <= w_err;
    end else if (w_handoff) begin
      r_out_valid <= 1'b0;
      if (!r_err) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign instruction_out = r_instr;
  assign err             = r_err;
  assign instr_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encode.sv
// ============================================================================
// tb_instr_encode : self-checking bench for instr_encode against a field-level model
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_encode;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               op_sel;
  logic [4:0]               reg_d;
  logic [4:0]               reg_n;
  logic [4:0]               reg_m;
  logic signed [`WORD-1:0]  imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [`INSTR_LEN-1:0]    instruction_out;
  logic                     err;
  logic [15:0]              instr_count;

  int n_tests   = 0;
  int n_fail    = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  instr_encode dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op_sel          (op_sel),
    .reg_d           (reg_d),
    .reg_n           (reg_n),
    .reg_m           (reg_m),
    .imm             (imm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instruction_out (instruction_out),
    .err             (err),
    .instr_count     (instr_count)
  );

  // Reference model: builds the word from field weights and signed ranges.
  function automatic logic [32:0] model(input int op, input int d, input int n,
                                        input int m, input longint im);
    longint v;
    longint opc;
    logic   e;
    v = 0;
    e = 1'b0;
    case (op)
      0, 1: begin
        opc = (op == 0) ? 64'h7C2 : 64'h7C0;
        if (im < -256 || im > 255) e = 1'b1;
        else v = opc * 2097152 + ((im % 512 + 512) % 512) * 4096 + n * 32 + d;
      end
      2, 3, 4, 5: begin
        opc = (op == 2) ? 64'h458 : (op == 3) ? 64'h658 : (op == 4) ? 64'h450 : 64'h550;
        v = opc * 2097152 + m * 65536 + n * 32 + d;
      end
      6: begin
        if (im < -262144 || im > 262143) e = 1'b1;
        else v = longint'(180) * 16777216 + ((im % 524288 + 524288) % 524288) * 32 + d;
      end
      7: begin
        if (im < -33554432 || im > 33554431) e = 1'b1;
        else v = longint'(5) * 67108864 + (im % 67108864 + 67108864) % 67108864;
      end
      default: e = 1'b1;
    endcase
    return {e, v[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits for the result; lat counts the accept edge as edge 1.
  task automatic send(input int op, input int d, input int n, input int m, input longint im,
                      output logic [31:0] ins, output logic e, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    op_sel   = op[3:0];
    reg_d    = d[4:0];
    reg_n    = n[4:0];
    reg_m    = m[4:0];
    imm      = im;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op_sel   = 4'($urandom);
    reg_d    = 5'($urandom);
    reg_n    = 5'($urandom);
    reg_m    = 5'($urandom);
    imm      = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    ins = instruction_out;
    e   = err;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    step();
    step();
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0 || err !== 1'b0 || instruction_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b i=%h want 0/0/0", out_valid, err, instruction_out);
    end
    n_tests++;
    if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0", instr_count); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    step();
    exp_count = 0;
  endtask

  typedef struct {
    int          op;
    int          d;
    int          n;
    int          m;
    longint      im;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t        v[10];
    logic [31:0] ins;
    logic        e;
    int          lat;
    v[0] = '{0,  9, 22,  0,  64, 32'hF84402C9};
    v[1] = '{2, 10, 19,  9,   0, 32'h8B09026A};
    v[2] = '{3, 11, 20, 10,   0, 32'hCB0A028B};
    v[3] = '{5,  9, 10, 21,   0, 32'hAA150149};
    v[4] = '{1, 11, 22,  0,  96, 32'hF80602CB};
    v[5] = '{6, 11,  0,  0,  -5, 32'hB4FFFF6B};
    v[6] = '{6,  9,  0,  0,   8, 32'hB4000109};
    v[7] = '{7,  0,  0,  0,  64, 32'h14000040};
    v[8] = '{7,  0,  0,  0, -55, 32'h17FFFFC9};
    v[9] = '{0,  0,  0,  0, -256, 32'hF8500000};
    for (int i = 0; i < 10; i++) begin
      send(v[i].op, v[i].d, v[i].n, v[i].m, v[i].im, ins, e, lat);
      n_tests++;
      if (ins !== v[i].exp || e !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d]: got %h err=%b want %h err=0", i, ins, e, v[i].exp);
      end
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 2", i, lat); end
      handoff();
      exp_count = (exp_count + 1) % 65536;
      n_tests++;
      if (out_valid !== 1'b0 || instr_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL directed_handoff[%0d]: got v=%b cnt=%h want 0/%h", i, out_valid, instr_count, exp_count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins;
    logic        e;
    int          lat;
    send(4, 31, 7, 31, 0, ins, e, lat);
    n_tests++;
    if (ins !== 32'h8A1F00FF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_and_xzr: got %h err=%b want 8a1f00ff err=0", ins, e);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_sel = 4'($urandom);
      reg_d  = 5'($urandom);
      imm    = {$urandom, $urandom};
      step();
      n_tests++;
      if (out_valid !== 1'b1 || instruction_out !== ins || err !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b i=%h e=%b rdy=%b want 1/%h/0/0",
                 i, out_valid, instruction_out, err, in_ready, ins);
      end
    end
    in_valid  = 1'b0;
    handoff();
    exp_count = (exp_count + 1) % 65536;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b rdy=%b cnt=%h want 0/1/%h", out_valid, in_ready, instr_count, exp_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_no_accept[%0d]: got v=%b rdy=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ins;
    logic        e;
    int          lat;
    int          ops[3];
    longint      ims[3];
    ops = '{0, 9, 7};
    ims = '{256, 0, 33554432};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 5, 6, 7, ims[i], ins, e, lat);
      n_tests++;
      if (e !== 1'b1 || ins !== 32'd0 || lat !== 2) begin
        n_fail++;
        $display("FAIL error[%0d]: got err=%b i=%h lat=%0d want 1/0/2", i, e, ins, lat);
      end
      handoff();
      n_tests++;
      if (instr_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL error_count[%0d]: got %h want %h", i, instr_count, exp_count);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        e;
    logic [32:0] ref_v;
    int          lat;
    int          op, d, n, m;
    longint      im;
    for (int t = 0; t < 400; t++) begin
      op = $urandom_range(0, 9);
      if (op >= 8) op = $urandom_range(8, 15);
      d = $urandom_range(0, 31);
      n = $urandom_range(0, 31);
      m = $urandom_range(0, 31);
      case ($urandom_range(0, 5))
        0: im = longint'($urandom_range(0, 600)) - 300;
        1: im = (longint'($urandom_range(0, 1)) * 2 - 1) * 256 + longint'($urandom_range(0, 1)) - 1;
        2: im = (longint'($urandom_range(0, 1)) * 2 - 1) * 262144 + longint'($urandom_range(0, 1)) - 1;
        3: im = (longint'($urandom_range(0, 1)) * 2 - 1) * 33554432 + longint'($urandom_range(0, 1)) - 1;
        4: im = longint'($urandom_range(0, 67108863)) - 33554432;
        default: im = longint'({$urandom, $urandom});
      endcase
      ref_v = model(op, d, n, m, im);
      send(op, d, n, m, im, ins, e, lat);
      n_tests++;
      if (ins !== ref_v[31:0] || e !== ref_v[32] || lat !== 2) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d imm=%0d: got %h err=%b lat=%0d want %h err=%b lat=2",
                 t, op, im, ins, e, lat, ref_v[31:0], ref_v[32]);
      end
      repeat ($urandom_range(0, 3)) begin
        step();
        n_tests++;
        if (out_valid !== 1'b1 || instruction_out !== ins) begin
          n_fail++;
          $display("FAIL random_stall[%0d]: got v=%b i=%h want 1/%h", t, out_valid, instruction_out, ins);
        end
      end
      handoff();
      if (!ref_v[32]) exp_count = (exp_count + 1) % 65536;
      n_tests++;
      if (instr_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL random_count[%0d]: got %h want %h", t, instr_count, exp_count);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] ins;
    logic        e;
    int          lat;
    reset = 1'b1;
    step();
    reset     = 1'b0;
    exp_count = 0;
    op_sel    = 4'd2;
    reg_d     = 5'd1;
    reg_n     = 5'd2;
    reg_m     = 5'd3;
    imm       = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    // Each back-to-back handoff spends one cycle in each of IDLE, ENCODE and HOLD.
    repeat (3 * 65535) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (instr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", instr_count); end
    send(2, 1, 2, 3, 0, ins, e, lat);
    handoff();
    n_tests++;
    if (instr_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover: got %h want 0000", instr_count); end
    send(3, 4, 5, 6, 0, ins, e, lat);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_hold: got v=%b want 1", out_valid); end
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || instr_count !== 16'h0000 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_hold: got v=%b cnt=%h rdy=%b want 0/0000/0", out_valid, instr_count, in_ready);
    end
    reset     = 1'b0;
    out_ready = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || instr_count !== 16'h0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_in_hold: got v=%b cnt=%h rdy=%b want 0/0000/1", out_valid, instr_count, in_ready);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_sel    = '0;
    reg_d     = '0;
    reg_n     = '0;
    reg_m     = '0;
    imm       = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_errors();
    test_random();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
